// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite SRAM responder: byte/halfword/word lanes, a configurable number of
// wait states per OKAY beat and the two-cycle ERROR response.
module ahb_lite_slave_mem #(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              rst,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * 4);

    typedef enum logic [1:0] {S_RDY, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       wait_cnt;
    logic [2:0]       wait_cnt_nxt;

    logic [31:0]      mem [DEPTH];

    logic             pend_valid;
    logic             pend_write;
    logic [IDX_W-1:0] pend_idx;
    logic [3:0]       pend_mask;

    logic             accept;
    logic             addr_err;
    logic             accept_ok;
    logic             accept_err;
    logic [3:0]       lane_mask;
    logic [IDX_W-1:0] addr_idx;
    logic             commit;
    logic             rd_load;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_word;
    logic             unused_ok;

    // A stalling slave cannot take a new address, even if the master misdrives HREADY.
    assign accept     = HSEL & HTRANS[1] & HREADY & HREADYOUT;
    assign addr_err   = ({1'b0, HADDR} >= MEM_BYTES)
                      | (HSIZE > 3'd2)
                      | ((HSIZE == 3'd1) & HADDR[0])
                      | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
    assign accept_ok  = accept & ~addr_err;
    assign accept_err = accept & addr_err;
    assign addr_idx   = HADDR[IDX_W+1:2];
    assign commit     = HREADYOUT & pend_valid & pend_write & ~rst;
    assign unused_ok  = ^{HBURST, HTRANS[0]};

    always_comb begin
        lane_mask = 4'b1111;
        case (HSIZE)
            3'd0:    lane_mask = 4'b0001 << HADDR[1:0];
            3'd1:    lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (rst) begin
            state    <= S_RDY;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_RDY, S_ERR2: begin
                state_nxt = S_RDY;
                if (accept_err) begin
                    state_nxt = S_ERR1;
                end else if (accept_ok && (WAIT_STATES > 0)) begin
                    state_nxt    = S_WAIT;
                    wait_cnt_nxt = 3'(WAIT_STATES - 1);
                end
            end
            S_WAIT: begin
                if (wait_cnt == 3'd0) begin
                    state_nxt = S_RDY;
                end else begin
                    wait_cnt_nxt = wait_cnt - 3'd1;
                end
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_RDY;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            S_WAIT: HREADYOUT = 1'b0;
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2:  HRESP = 1'b1;
            default: ;
        endcase
    end

    // Without wait states the read word is fetched at the address edge; otherwise
    // at the edge that leaves the last wait cycle.
    always_comb begin
        if (WAIT_STATES == 0) begin
            rd_load = accept_ok & ~HWRITE;
            rd_idx  = addr_idx;
        end else begin
            rd_load = (state == S_WAIT) & (wait_cnt == 3'd0) & pend_valid & ~pend_write;
            rd_idx  = pend_idx;
        end
    end

    // Forward bytes being committed on this same edge so a pipelined read never sees stale data.
    always_comb begin
        rd_word = mem[rd_idx];
        if (commit && (pend_idx == rd_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_mask[b]) begin
                    rd_word[8*b +: 8] = HWDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_write <= 1'b0;
            pend_idx   <= '0;
            pend_mask  <= '0;
            HRDATA     <= '0;
        end else begin
            if (accept) begin
                pend_valid <= accept_ok;
                pend_write <= HWRITE;
                pend_idx   <= addr_idx;
                pend_mask  <= lane_mask;
            end else if (HREADYOUT) begin
                pend_valid <= 1'b0;
            end
            if (rd_load) begin
                HRDATA <= rd_word;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (pend_mask[b]) begin
                    mem[pend_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Bench for ahb_lite_slave_mem: a zero-wait and a three-wait instance driven by a
// pipelined AHB master task and compared against a byte-addressed memory model.
module tb_ahb_lite_slave_mem;

    typedef struct {
        bit          write;
        logic [11:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        HCLK = 1'b0;
    logic        rst = 1'b1;
    logic        hsel = 1'b0;
    logic [11:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [2:0]  hburst = '0;
    logic [31:0] hwdata = '0;
    int          target = 0;

    logic        hsel_0, hsel_1;
    logic [31:0] hrdata_0, hrdata_1;
    logic        hreadyout_0, hreadyout_1;
    logic        hresp_0, hresp_1;
    logic [31:0] rdata_m;
    logic        ready_m, resp_m;

    byte unsigned ref_mem [2][1024];
    logic [31:0]  last_rdata [2];
    xfer_t        xq[$];
    int           data_cycles = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           n_fail = 0;

    assign hsel_0  = hsel && (target == 0);
    assign hsel_1  = hsel && (target == 1);
    assign rdata_m = (target == 0) ? hrdata_0 : hrdata_1;
    assign ready_m = (target == 0) ? hreadyout_0 : hreadyout_1;
    assign resp_m  = (target == 0) ? hresp_0 : hresp_1;

    ahb_lite_slave_mem #(.ADDR_W(12), .DEPTH(256), .WAIT_STATES(0)) dut_0 (
        .HCLK(HCLK), .rst(rst), .HSEL(hsel_0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hreadyout_0), .HRDATA(hrdata_0), .HREADYOUT(hreadyout_0), .HRESP(hresp_0)
    );

    ahb_lite_slave_mem #(.ADDR_W(12), .DEPTH(256), .WAIT_STATES(3)) dut_3 (
        .HCLK(HCLK), .rst(rst), .HSEL(hsel_1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hreadyout_1), .HRDATA(hrdata_1), .HREADYOUT(hreadyout_1), .HRESP(hresp_1)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [11:0] a, input logic [2:0] s);
        int unsigned ai = a;
        return (ai >= 1024) || (s > 3'd2) || (s == 3'd1 && ai % 2 != 0) || (s == 3'd2 && ai % 4 != 0);
    endfunction

    function automatic logic [31:0] model_word(input int t, input int a);
        int b = a - (a % 4);
        return {ref_mem[t][b+3], ref_mem[t][b+2], ref_mem[t][b+1], ref_mem[t][b]};
    endfunction

    task automatic push(input bit w, input logic [11:0] a, input logic [2:0] s, input logic [31:0] d);
        xfer_t x;
        x.write = w;
        x.addr  = a;
        x.size  = s;
        x.wdata = d;
        xq.push_back(x);
    endtask

    // Retire one transfer in the model at the cycle its data phase completes.
    task automatic finish_xfer(input int t, input xfer_t x, input bit err);
        int a = int'(x.addr);
        if (err || x.write) begin
            checkOutput(err ? "err_rdata_hold" : "wr_rdata_hold", rdata_m, last_rdata[t]);
        end
        if (!err && x.write) begin
            for (int i = 0; i < (1 << x.size); i++) begin
                ref_mem[t][a+i] = x.wdata[8*((a+i)%4) +: 8];
            end
        end else if (!err) begin
            checkOutput("read_data", rdata_m, model_word(t, a));
            last_rdata[t] = model_word(t, a);
        end
    endtask

    task automatic applyStimulus(input int tgt, input bit gaps);
        int ai = 0;
        int di = -1;
        int dcyc = 0;
        int cycles = 0;
        int ws = (tgt == 0) ? 0 : 3;
        bit present, rdy_now, err;
        target = tgt;
        data_cycles = 0;
        while ((ai < xq.size() || di >= 0) && cycles < 4000) begin
            @(negedge HCLK);
            cycles++;
            rdy_now = ready_m;
            if (di >= 0) begin
                data_cycles++;
                err = model_err(xq[di].addr, xq[di].size);
                if (err) begin
                    checkOutput("err_ready", rdy_now, dcyc >= 1);
                    checkOutput("err_resp", resp_m, 1);
                end else begin
                    checkOutput("ok_ready", rdy_now, dcyc >= ws);
                    checkOutput("ok_resp", resp_m, 0);
                end
                if (rdy_now) finish_xfer(tgt, xq[di], err);
            end else begin
                checkOutput("idle_ready", rdy_now, 1);
                checkOutput("idle_resp", resp_m, 0);
            end
            present = (ai < xq.size()) && !(gaps && $urandom_range(0, 3) == 0);
            if (present) begin
                hsel   = 1'b1;
                haddr  = xq[ai].addr;
                htrans = (ai == 0) ? 2'b10 : 2'b11;
                hwrite = xq[ai].write;
                hsize  = xq[ai].size;
                hburst = 3'($urandom_range(0, 7));
            end else if (gaps) begin
                hsel   = 1'($urandom_range(0, 1));
                htrans = hsel ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
                haddr  = 12'($urandom);
                hwrite = 1'($urandom_range(0, 1));
                hsize  = 3'($urandom_range(0, 2));
            end else begin
                hsel   = 1'b0;
                htrans = 2'b00;
            end
            hwdata = (di >= 0 && xq[di].write) ? xq[di].wdata : $urandom;
            @(posedge HCLK);
            if (rdy_now) begin
                di = present ? ai : -1;
                if (present) ai++;
                dcyc = 0;
            end else begin
                dcyc++;
            end
        end
        checkOutput("sequence_done", (ai == xq.size()) && (di < 0), 1);
        hsel   = 1'b0;
        htrans = 2'b00;
        xq.delete();
    endtask

    task automatic random_round(input int tgt, input int count);
        xfer_t x;
        for (int n = 0; n < count; n++) begin
            x.write = 1'($urandom_range(0, 1));
            x.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       x.addr = 12'($urandom_range(1024, 4095));
                1, 2, 3: x.addr = 12'($urandom_range(0, 1023));
                default: x.addr = 12'($urandom_range(0, 31));
            endcase
            if ($urandom_range(0, 4) != 0) x.addr = x.addr & ~(12'(1 << x.size) - 12'd1);
            x.wdata = $urandom;
            xq.push_back(x);
        end
        applyStimulus(tgt, 1'b1);
    endtask

    initial begin
        last_rdata[0] = '0;
        last_rdata[1] = '0;

        repeat (3) @(negedge HCLK);
        checkOutput("reset_ready_0", hreadyout_0, 1);
        checkOutput("reset_resp_0", hresp_0, 0);
        checkOutput("reset_rdata_0", hrdata_0, 32'h0);
        checkOutput("reset_ready_3", hreadyout_1, 1);
        checkOutput("reset_resp_3", hresp_1, 0);
        checkOutput("reset_rdata_3", hrdata_1, 32'h0);
        rst = 1'b0;

        for (int w = 0; w < 256; w++) push(1'b1, 12'(w * 4), 3'd2, $urandom);
        applyStimulus(0, 1'b0);
        for (int w = 0; w < 256; w++) push(1'b1, 12'(w * 4), 3'd2, (w < 4) ? 32'(w + 1) : $urandom);
        applyStimulus(1, 1'b0);

        push(1'b1, 12'h010, 3'd2, 32'hDEADBEEF);
        push(1'b0, 12'h010, 3'd2, 32'h0);
        applyStimulus(0, 1'b0);
        @(negedge HCLK);
        checkOutput("tp_word_rw", rdata_m, 32'hDEADBEEF);

        push(1'b1, 12'h020, 3'd2, 32'h00000000);
        push(1'b1, 12'h021, 3'd0, 32'h0000AA00);
        push(1'b0, 12'h020, 3'd2, 32'h0);
        applyStimulus(0, 1'b0);
        @(negedge HCLK);
        checkOutput("tp_byte_lane", rdata_m, 32'h0000AA00);
        push(1'b1, 12'h022, 3'd1, 32'h12340000);
        push(1'b0, 12'h020, 3'd2, 32'h0);
        applyStimulus(0, 1'b0);
        @(negedge HCLK);
        checkOutput("tp_half_lane", rdata_m, 32'h1234AA00);

        push(1'b1, 12'h400, 3'd2, 32'h55555555);
        push(1'b0, 12'h000, 3'd2, 32'h0);
        push(1'b1, 12'h002, 3'd2, 32'h66666666);
        push(1'b0, 12'h000, 3'd3, 32'h0);
        push(1'b0, 12'h000, 3'd2, 32'h0);
        applyStimulus(0, 1'b0);

        push(1'b1, 12'h040, 3'd2, 32'hCAFEF00D);
        push(1'b0, 12'h040, 3'd2, 32'h0);
        applyStimulus(0, 1'b0);
        @(negedge HCLK);
        checkOutput("tp_bypass", rdata_m, 32'hCAFEF00D);

        for (int w = 0; w < 4; w++) push(1'b0, 12'(w * 4), 3'd2, 32'h0);
        applyStimulus(1, 1'b0);
        checkOutput("tp_ws_data_cycles", data_cycles, 16);
        @(negedge HCLK);
        checkOutput("tp_ws_last_beat", rdata_m, 32'h4);

        push(1'b1, 12'h404, 3'd2, 32'h77777777);
        push(1'b1, 12'h001, 3'd1, 32'h88888888);
        push(1'b0, 12'h000, 3'd2, 32'h0);
        applyStimulus(1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            random_round(0, 40);
            random_round(1, 40);
        end

        // Reset while a write is stalled in its wait states.
        push(1'b1, 12'h080, 3'd2, 32'h11111111);
        applyStimulus(1, 1'b0);
        @(negedge HCLK);
        hsel = 1'b1; haddr = 12'h080; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK);
        @(negedge HCLK);
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h22222222;
        checkOutput("rst_wait_ready", ready_m, 0);
        rst = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        rst = 1'b0;
        checkOutput("rst_wait_ready_after", ready_m, 1);
        checkOutput("rst_wait_resp_after", resp_m, 0);
        checkOutput("rst_wait_rdata_after", rdata_m, 32'h0);
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        push(1'b0, 12'h080, 3'd2, 32'h0);
        applyStimulus(1, 1'b0);
        @(negedge HCLK);
        checkOutput("rst_wait_write_dropped", rdata_m, 32'h11111111);

        // Reset during ERR1 must not leave an ERR2 cycle behind.
        target = 0;
        @(negedge HCLK);
        hsel = 1'b1; haddr = 12'h400; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK);
        @(negedge HCLK);
        hsel = 1'b0; htrans = 2'b00;
        checkOutput("rst_err1_ready", ready_m, 0);
        checkOutput("rst_err1_resp", resp_m, 1);
        rst = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        rst = 1'b0;
        checkOutput("rst_err_ready_after", ready_m, 1);
        checkOutput("rst_err_resp_after", resp_m, 0);
        @(negedge HCLK);
        checkOutput("rst_err_no_err2_ready", ready_m, 1);
        checkOutput("rst_err_no_err2_resp", resp_m, 0);
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        push(1'b0, 12'h010, 3'd2, 32'h0);
        push(1'b0, 12'h080, 3'd2, 32'h0);
        applyStimulus(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_slave_mem.md
# ahb_lite_slave_mem

AHB-Lite responder: a word-organised SRAM slave with byte/halfword/word access, configurable wait states and a two-cycle ERROR response. It is the target-side counterpart of the bridge's AHB master controller. It serves as the local buffer and register space the master bursts into and out of ahead of the SPI path, and as the bench target for the master.

## Interface
- ADDR_W, 12: byte-address width of HADDR.
- DEPTH, 256: memory depth in 32-bit words. DEPTH*4 must be ≤ 2^ADDR_W.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted in every OKAY data phase, range 0–7.
- HCLK  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_W  byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 byte, 1 halfword, 2 word.
- HBURST  in  3  ignored; every beat is decoded independently.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready, used to qualify the address phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.

## Operation
- **Address phase accept:** a transfer is accepted at a posedge where HSEL & HTRANS[1] & HREADY are all 1. At that edge the block registers the address, write flag, size and error flag.
- **IDLE/BUSY, or HSEL=0 with HREADY=1:** no transfer. The next cycle gives HREADYOUT=1, HRESP=0 with zero wait.
- **Error decode:** the transfer is an error if any of these holds:
  - HADDR ≥ DEPTH*4;
  - HSIZE > 2;
  - HSIZE=1 with HADDR[0]=1;
  - HSIZE=2 with HADDR[1:0]≠0.
- **Error effect:** an error transfer never writes memory, and HRDATA holds its previous value.
- **FSM states:**
  - **RDY:** HREADYOUT=1, HRESP=0.
  - **WAIT:** HREADYOUT=0, HRESP=0. Wait counter runs.
  - **ERR1:** HREADYOUT=0, HRESP=1.
  - **ERR2:** HREADYOUT=1, HRESP=1.
- **FSM transitions:**
  - On accepting an OKAY transfer: go to WAIT (counter = WAIT_STATES-1) if WAIT_STATES>0, else stay in RDY.
  - On accepting an error transfer: go to ERR1.
  - WAIT: go to RDY when the counter reaches 0, otherwise decrement.
  - ERR1: always go to ERR2.
  - ERR2: behaves like RDY for accept purposes, so a new transfer can be accepted in ERR2.
- **Write commit:** occurs at the edge that ends the data phase (the edge where HREADYOUT=1 for that transfer). The byte lanes of HWDATA are selected by HSIZE/HADDR[1:0], little-endian: byte n is HWDATA[8n+7:8n]. Unselected bytes are unchanged.
- **Read:** the memory word is registered into HRDATA so that it is valid in the cycle HREADYOUT=1 ends the data phase. The full 32-bit word is returned regardless of HSIZE.
- **Write-to-read bypass:** a read whose address phase is accepted at the same edge as a write commit to the same word must return the merged, newly written bytes. No stale data is allowed.
- **Reset:** HREADYOUT=1, HRESP=0, HRDATA=0, FSM=RDY, wait counter 0, pending transfer cleared. Memory contents are not reset.
- **Reset mid-transfer:** a pending write is discarded. Reset mid-error terminates the error sequence, with no ERR2 cycle.

## Timing
- OKAY latency from address-phase edge to data-phase completion is WAIT_STATES+1 cycles. With WAIT_STATES=0, back-to-back NONSEQ/SEQ sustain one beat per cycle.
- ERROR is always exactly two data-phase cycles: HREADYOUT 0 then 1, with HRESP=1 in both. WAIT_STATES does not apply to errors.
- While HREADYOUT=0, HREADY is expected to be 0. Address-phase signals are then not sampled, since acceptance is gated by HREADY.
- HRDATA changes only on the edge that makes a read's data phase ready.
- A master dropping to IDLE during ERR1 has no effect on the ERR2 cycle.

## Test plan
- **Word write/read, WAIT_STATES=0:** NONSEQ write 0xDEADBEEF to 0x010, then NONSEQ read 0x010 → HRDATA=0xDEADBEEF one cycle after the read address phase, HREADYOUT never 0.
- **Byte/halfword lanes:**
  - Word write 0x00000000 to 0x020.
  - Byte write 0xAA at 0x021 → word reads 0x0000AA00.
  - Halfword write 0x1234 at 0x022 → word reads 0x1234AA00.
- **Wait states, WAIT_STATES=3:** 4-beat read burst 0x000–0x00C → each beat shows 3 cycles HREADYOUT=0, then 1. Total 16 data cycles, with data matching preloaded 1, 2, 3, 4.
- **Errors:**
  - Write to 0x400 with DEPTH=256 → HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1; subsequent read of 0x000 is unchanged.
  - Word access at 0x002 → ERROR.
  - HSIZE=3 → ERROR.
- **Bypass:** write 0xCAFEF00D to 0x040 immediately followed (pipelined) by a read of 0x040 → read returns 0xCAFEF00D.
- **Reset mid-operation:** assert rst during a WAIT cycle of a write to 0x080 holding 0x11111111 → outputs return to reset values next cycle, and a later read of 0x080 returns 0x11111111.
